// File: rtl/mem_burst_engine.sv
// Burst access controller for a single-port synchronous-read RAM.
// READ bursts stream words from the RAM through a 2-entry output FIFO.
// WRITE bursts move words from an input stream into the RAM.
// Addresses wrap modulo the RAM depth. An additive checksum of all
// transferred words is reported when the burst completes.
module mem_burst_engine #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] csum,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_dat_w,
  input  logic [DATA_W-1:0] mem_dat_r,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last_adr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_clamped;
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] last_dat_w;

  // Output FIFO: two data slots, one-bit pointers, occupancy 0..2.
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              in_flight;
  logic [1:0]        occ;

  logic rd_issue;
  logic rd_pop;
  logic wr_fire;

  // Handshakes, read issue decision and RAM/stream port drive.
  // NOTE: every signal written in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    out_valid   = (fifo_cnt != 2'd0);
    out_data    = fifo_mem[rd_ptr];
    rd_pop      = (state == S_RD) && out_valid && out_ready;
    // Slots that will be taken after this cycle: a popped word frees its slot
    // in time for a read issued now, which keeps the stream at one word/cycle.
    occ         = fifo_cnt + {1'b0, in_flight} - {1'b0, rd_pop};
    rd_issue    = (state == S_RD) && (remaining != '0) && (occ < 2'd2);
    in_ready    = (state == S_WR) && (remaining != '0);
    wr_fire     = in_ready && in_valid;
    mem_we      = wr_fire;
    mem_adr     = (rd_issue || wr_fire) ? addr : last_adr;
    mem_dat_w   = wr_fire ? in_data : last_dat_w;
    busy        = (state != S_IDLE);
    done        = (state == S_FIN);
    csum        = csum_q;
  end

  // Next-state selection for the burst sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_clamped == '0) state_nxt = S_FIN;
          else if (mode)         state_nxt = S_WR;
          else                   state_nxt = S_RD;
        end
      end
      S_RD: begin
        if ((remaining == '0) && !in_flight && (fifo_cnt == 2'd0)) state_nxt = S_FIN;
      end
      S_WR: begin
        if (remaining == '0) state_nxt = S_FIN;
      end
      S_FIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Address/length counters, checksum and held RAM port values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      remaining  <= '0;
      csum_q     <= '0;
      last_adr   <= '0;
      last_dat_w <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        addr      <= base;
        remaining <= len_clamped;
        csum_q    <= '0;
      end else begin
        if (rd_issue || wr_fire) begin
          addr      <= addr + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
        end
        if (rd_pop)       csum_q <= csum_q + out_data;
        else if (wr_fire) csum_q <= csum_q + in_data;
      end
      if (rd_issue || wr_fire) last_adr   <= addr;
      if (wr_fire)             last_dat_w <= in_data;
    end
  end

  // FIFO pointers, occupancy and the one-cycle read-in-flight marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      in_flight <= rd_issue;
      if (in_flight) wr_ptr <= ~wr_ptr;
      if (rd_pop)    rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, in_flight} - {1'b0, rd_pop};
    end
  end

  // Capture RAM read data one cycle after the read was issued.
  // NOTE: FIFO data slots are not reset; out_valid is derived from the reset occupancy count.
  always_ff @(posedge clk) begin
    if (in_flight) fifo_mem[wr_ptr] <= mem_dat_r;
  end

endmodule

// File: tb/tb_mem_burst_engine.sv
// Self-checking bench for mem_burst_engine with a behavioural 16x8
// synchronous-read RAM and a scoreboard of expected stream words.
module tb_mem_burst_engine;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [3:0] base;
  logic [4:0] len;
  logic       busy;
  logic       done;
  logic [7:0] csum;
  logic [3:0] mem_adr;
  logic       mem_we;
  logic [7:0] mem_dat_w;
  logic [7:0] mem_dat_r;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  logic       preload;
  logic [7:0] ram     [16];
  logic [7:0] exp_mem [16];
  logic [7:0] sb [$];
  logic [7:0] wq [$];

  int n_tests;
  int n_fail;

  localparam int BUDGET = 200;

  mem_burst_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .csum      (csum),
    .mem_adr   (mem_adr),
    .mem_we    (mem_we),
    .mem_dat_w (mem_dat_w),
    .mem_dat_r (mem_dat_r),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: write-enable plus registered read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(i + 8'h10);
    end else begin
      if (mem_we) ram[mem_adr] <= mem_dat_w;
      mem_dat_r <= ram[mem_adr];
    end
  end

  function automatic logic ready_for(input int pat, input int k);
    if (pat == 0) return 1'b1;
    return ((k - 1) % 3 == 0);
  endfunction

  // Runs a READ burst; expected words come from the bench memory model.
  task automatic read_burst(input logic [3:0] b, input logic [4:0] l, input int pat,
                            input bit chk_lat, input bit poke);
    int         eff;
    logic [3:0] a;
    logic [7:0] exp_sum;
    logic [7:0] got_sum;
    int         first_valid;
    int         last_pop;
    int         done_k;
    eff     = (l > 5'd16) ? 16 : int'(l);
    exp_sum = 8'h00;
    sb.delete();
    for (int i = 0; i < eff; i++) begin
      a = b + 4'(i);
      sb.push_back(exp_mem[a]);
      exp_sum = exp_sum + exp_mem[a];
    end
    first_valid = 0;
    last_pop    = 0;
    done_k      = 0;
    got_sum     = 8'hxx;
    @(negedge clk);
    mode = 1'b0; base = b; len = l; start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1; mode = 1'b1; base = b + 4'd7; len = 5'd9;
      end
      if (poke && k == 3) mode = 1'b0;
      out_ready = ready_for(pat, k);
      #1;
      n_tests++;
      if (mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_mem_we k=%0d got=%b exp=0", k, mem_we);
      end
      if (k == 1) begin
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL rd_busy got=%b exp=1", busy);
        end
      end
      if (out_valid === 1'b1) begin
        if (first_valid == 0) first_valid = k;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rd_extra_word k=%0d got=%h exp=none", k, out_data);
        end else begin
          if (out_data !== sb[0]) begin
            n_fail++;
            $display("FAIL rd_data k=%0d got=%h exp=%h", k, out_data, sb[0]);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            last_pop = k;
          end
        end
      end
      if (done === 1'b1) begin
        done_k  = k;
        got_sum = csum;
        break;
      end
    end
    n_tests++;
    if (done_k == 0) begin
      n_fail++;
      $display("FAIL rd_timeout got=no_done exp=done within %0d cycles", BUDGET);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rd_missing got=%0d_left exp=0_left", sb.size());
    end
    n_tests++;
    if (got_sum !== exp_sum) begin
      n_fail++;
      $display("FAIL rd_csum got=%h exp=%h", got_sum, exp_sum);
    end
    if (chk_lat) begin
      n_tests++;
      if (first_valid != 3 || last_pop != 2 + eff) begin
        n_fail++;
        $display("FAIL rd_latency got=first%0d_last%0d exp=first3_last%0d",
                 first_valid, last_pop, 2 + eff);
      end
    end
    if (eff == 0) begin
      n_tests++;
      if (done_k != 1) begin
        n_fail++;
        $display("FAIL rd_len0_done got=%0d exp=1", done_k);
      end
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after_done got=busy%b_done%b exp=busy0_done0", busy, done);
    end
  endtask

  // Runs a WRITE burst of the words queued in wq; gap=1 drops in_valid on even cycles.
  task automatic write_burst(input logic [3:0] b, input logic [4:0] l, input bit gap);
    int         eff;
    int         idx;
    int         done_k;
    logic [3:0] a;
    logic [7:0] exp_sum;
    logic [7:0] got_sum;
    logic       exp_rdy;
    eff     = (l > 5'd16) ? 16 : int'(l);
    exp_sum = 8'h00;
    for (int i = 0; i < eff; i++) begin
      a = b + 4'(i);
      exp_mem[a] = wq[i];
      exp_sum = exp_sum + wq[i];
    end
    idx     = 0;
    done_k  = 0;
    got_sum = 8'hxx;
    @(negedge clk);
    mode = 1'b1; base = b; len = l; start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = gap ? (k % 2 == 1) : 1'b1;
      in_data  = (idx < eff) ? wq[idx] : 8'hEE;
      #1;
      exp_rdy = (idx < eff);
      n_tests++;
      if (in_ready !== exp_rdy || mem_we !== (exp_rdy && in_valid)) begin
        n_fail++;
        $display("FAIL wr_handshake k=%0d got=rdy%b_we%b exp=rdy%b_we%b",
                 k, in_ready, mem_we, exp_rdy, exp_rdy && in_valid);
      end
      if (exp_rdy && in_valid) begin
        a = b + 4'(idx);
        n_tests++;
        if (mem_adr !== a || mem_dat_w !== wq[idx]) begin
          n_fail++;
          $display("FAIL wr_port k=%0d got=adr%h_dat%h exp=adr%h_dat%h",
                   k, mem_adr, mem_dat_w, a, wq[idx]);
        end
        idx++;
      end
      if (done === 1'b1) begin
        done_k  = k;
        got_sum = csum;
        break;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (done_k == 0 || idx != eff) begin
      n_fail++;
      $display("FAIL wr_complete got=done_k%0d_words%0d exp=done_words%0d", done_k, idx, eff);
    end
    n_tests++;
    if (got_sum !== exp_sum) begin
      n_fail++;
      $display("FAIL wr_csum got=%h exp=%h", got_sum, exp_sum);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (ram[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL wr_ram[%0d] got=%h exp=%h", i, ram[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || csum !== 8'h00 || mem_adr !== 4'h0 ||
        mem_we !== 1'b0 || mem_dat_w !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=busy%b done%b csum%h adr%h we%b dw%h ov%b ir%b exp=all_zero",
               busy, done, csum, mem_adr, mem_we, mem_dat_w, out_valid, in_ready);
    end
  endtask

  task automatic test_read_basic;
    read_burst(4'd3, 5'd4, 0, 1'b1, 1'b0);
  endtask

  task automatic test_read_wrap_stall;
    read_burst(4'd14, 5'd4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_write_wrap;
    wq.delete();
    wq.push_back(8'hAA); wq.push_back(8'h55); wq.push_back(8'h01);
    write_burst(4'd15, 5'd3, 1'b1);
    // Read the written words back across the wrap point.
    read_burst(4'd15, 5'd3, 0, 1'b1, 1'b0);
  endtask

  task automatic test_len_edges;
    read_burst(4'd6, 5'd0, 0, 1'b0, 1'b0);
    read_burst(4'd9, 5'd20, 0, 1'b1, 1'b0);
    wq.delete();
    write_burst(4'd2, 5'd0, 1'b0);
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    mode = 1'b1; base = 4'd5; len = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h31;
    @(negedge clk);
    in_data = 8'h32;
    @(negedge clk);
    in_data = 8'h33;
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || csum !== 8'h00 || mem_adr !== 4'h0 ||
        mem_we !== 1'b0 || mem_dat_w !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_write got=busy%b done%b csum%h adr%h we%b dw%h ov%b ir%b exp=all_zero",
               busy, done, csum, mem_adr, mem_we, mem_dat_w, out_valid, in_ready);
    end
    exp_mem[5] = 8'h31;
    exp_mem[6] = 8'h32;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (ram[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL rst_ram[%0d] got=%h exp=%h", i, ram[i], exp_mem[i]);
      end
    end
    read_burst(4'd5, 5'd3, 0, 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy;
    read_burst(4'd2, 5'd3, 1, 1'b0, 1'b1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    preload   = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    base      = 4'h0;
    len       = 5'h0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i + 8'h10);
    test_reset;
    @(negedge clk);
    @(negedge clk);
    preload = 1'b0;
    rst     = 1'b0;
    test_read_basic;
    test_read_wrap_stall;
    test_write_wrap;
    test_len_edges;
    test_reset_mid_write;
    test_start_while_busy;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
